// File: rtl/zigzag_buffer_if.sv
// Coefficient-stream bundle for zigzag_buffer: MDCT-side input plus the
// valid/ready zigzag output toward the quantizer.
interface zigzag_buffer_if #(
    parameter int DW = 12
);
    logic [DW-1:0] dcti;
    logic          idv;
    logic [DW-1:0] zzo;
    logic          odv;
    logic          ordy;
    logic          osob;
    logic          ovf;

    modport master (
        output dcti, idv, ordy,
        input  zzo, odv, osob, ovf
    );

    modport slave (
        input  dcti, idv, ordy,
        output zzo, odv, osob, ovf
    );
endinterface

// File: rtl/zigzag_buffer.sv
// Ping-pong 8x8 block buffer: raster-order coefficients in, JPEG zigzag order out.
// Define ZZ_TRANSPOSE_EN for column-major input (write address col*8+row).
module zigzag_buffer #(
    parameter int DW = 12
) (
    input  logic              clk,
    input  logic              rst,
    zigzag_buffer_if.slave    bus
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } rd_state_t;

    localparam logic [5:0] ZZ_TABLE [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    // Both banks share one array; the bank bit is the address MSB.
    logic [DW-1:0] r_mem [0:127];

    // Write side
    logic       r_wbank;
    logic [5:0] r_wcnt;
    logic [1:0] r_full;
    logic       r_ovf;

    // Read side: fetch pointer (r_fbank/r_rcnt) runs ahead of the release pointer
    logic       r_fbank;
    logic       r_rbank;
    logic [5:0] r_rcnt;
    rd_state_t  r_state;
    rd_state_t  w_state_next;

    // RAM read register stage, then output register stage
    logic [DW-1:0] r_pdata;
    logic          r_pvld;
    logic          r_psob;
    logic          r_plast;
    logic [DW-1:0] r_zzo;
    logic          r_odv;
    logic          r_osob;
    logic          r_olast;

    logic [5:0] w_waddr;
    logic       w_release;
    logic       w_accept;
    logic       w_wlast;
    logic       w_out_adv;
    logic       w_pipe_adv;
    logic       w_fetch;

`ifdef ZZ_TRANSPOSE_EN
    assign w_waddr = {r_wcnt[2:0], r_wcnt[5:3]};
`else
    assign w_waddr = r_wcnt;
`endif

    assign w_release  = r_odv & bus.ordy & r_olast;
    // A bank being released this cycle may take a write in the same cycle
    assign w_accept   = bus.idv & (~r_full[r_wbank] | (w_release & (r_rbank == r_wbank)));
    assign w_wlast    = w_accept & (r_wcnt == 6'd63);
    assign w_out_adv  = ~r_odv | bus.ordy;
    assign w_pipe_adv = ~r_pvld | w_out_adv;

    // ------------------------------------------------------------------
    // Block RAM: registered read, read enable doubles as the stall hold
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[{r_wbank, w_waddr}] <= bus.dcti;
        end
        if (w_fetch) begin
            r_pdata <= r_mem[{r_fbank, ZZ_TABLE[r_rcnt]}];
        end
    end

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wbank <= 1'b0;
            r_wcnt  <= 6'd0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wcnt <= r_wcnt + 6'd1;
                if (r_wcnt == 6'd63) begin
                    r_wbank <= ~r_wbank;
                end
            end else if (bus.idv) begin
                r_ovf <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_full
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_full[gi] <= 1'b0;
                end else begin
                    if (w_release && (r_rbank == 1'(gi))) begin
                        r_full[gi] <= 1'b0;
                    end
                    if (w_wlast && (r_wbank == 1'(gi))) begin
                        r_full[gi] <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_fetch      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_fbank]) begin
                    w_state_next = S_STREAM;
                    w_fetch      = w_pipe_adv;
                end
            end
            S_STREAM: begin
                // Fetching the next bank while the current one drains avoids a bubble
                w_fetch = r_full[r_fbank] & w_pipe_adv;
                if (w_release && !r_full[~r_rbank]) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Fetch pointer and two-stage output pipeline
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fbank <= 1'b0;
            r_rbank <= 1'b0;
            r_rcnt  <= 6'd0;
            r_pvld  <= 1'b0;
            r_psob  <= 1'b0;
            r_plast <= 1'b0;
            r_zzo   <= '0;
            r_odv   <= 1'b0;
            r_osob  <= 1'b0;
            r_olast <= 1'b0;
        end else begin
            if (w_fetch) begin
                r_rcnt <= r_rcnt + 6'd1;
                if (r_rcnt == 6'd63) begin
                    r_fbank <= ~r_fbank;
                end
            end
            if (w_release) begin
                r_rbank <= ~r_rbank;
            end
            if (w_pipe_adv) begin
                r_pvld  <= w_fetch;
                r_psob  <= w_fetch & (r_rcnt == 6'd0);
                r_plast <= w_fetch & (r_rcnt == 6'd63);
            end
            if (w_out_adv) begin
                r_odv   <= r_pvld;
                r_osob  <= r_pvld & r_psob;
                r_olast <= r_pvld & r_plast;
                if (r_pvld) begin
                    r_zzo <= r_pdata;
                end
            end
        end
    end

    assign bus.zzo  = r_zzo;
    assign bus.odv  = r_odv;
    assign bus.osob = r_osob;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_zigzag_buffer.sv
// Directed self-checking bench for zigzag_buffer: latency, ordering, stalls,
// back-to-back blocks, overflow and mid-stream reset.
module tb_zigzag_buffer;

    logic clk;
    logic rst;

    zigzag_buffer_if #(.DW(12)) bus ();

    zigzag_buffer #(.DW(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int zz_tab [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    logic [11:0] got_q [$];
    logic        sob_q [$];
    int cyc        = 0;
    int first_odv  = 0;
    int last_odv   = 0;
    int odv_cycles = 0;

    // Raster index delivered at zigzag position k when dcti = raster index
    function automatic int exp_addr(input int k);
`ifdef ZZ_TRANSPOSE_EN
        return (zz_tab[k] % 8) * 8 + zz_tab[k] / 8;
`else
        return zz_tab[k];
`endif
    endfunction

    // One clock: sample outputs at the falling edge, then drive the next inputs.
    task automatic step(input logic v, input int d, input logic r);
        @(negedge clk);
        cyc++;
        bus.idv  = v;
        bus.dcti = 12'(d);
        bus.ordy = r;
        if (bus.odv) begin
            odv_cycles++;
            if (first_odv == 0) first_odv = cyc;
            last_odv = cyc;
        end
        if (bus.odv && r) begin
            $display("out %0d: zzo=%0d sob=%0b ovf=%0b", got_q.size(), bus.zzo, bus.osob, bus.ovf);
            got_q.push_back(bus.zzo);
            sob_q.push_back(bus.osob);
        end
    endtask

    task automatic clear_log();
        got_q.delete();
        sob_q.delete();
        first_odv  = 0;
        last_odv   = 0;
        odv_cycles = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.idv = 1'b0; bus.dcti = '0; bus.ordy = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.zzo !== 12'd0) begin errors++; $display("FAIL reset_zzo: got %0d expected 0", bus.zzo); end
        checks++; if (bus.odv !== 1'b0) begin errors++; $display("FAIL reset_odv: got %b expected 0", bus.odv); end
        checks++; if (bus.osob !== 1'b0) begin errors++; $display("FAIL reset_osob: got %b expected 0", bus.osob); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        int feed_end;
        logic [11:0] g;
        clear_log();
        for (int i = 0; i < 64; i++) step(1'b1, i, 1'b1);
        feed_end = cyc;
        for (int j = 0; j < 100; j++) step(1'b0, 0, 1'b1);
        checks++;
        if (first_odv - feed_end !== 3) begin
            errors++; $display("FAIL single_latency: first odv %0d cycles after last sample, expected 3", first_odv - feed_end);
        end
        checks++; if (got_q.size() != 64) begin errors++; $display("FAIL single_count: got %0d outputs expected 64", got_q.size()); end
        for (int k = 0; k < 64; k++) begin
            g = (k < got_q.size()) ? got_q[k] : 12'bx;
            checks++; if (g !== 12'(exp_addr(k))) begin errors++; $display("FAIL single_data[%0d]: got %0d expected %0d", k, g, exp_addr(k)); end
            if (k < sob_q.size()) begin
                checks++; if (sob_q[k] !== (k == 0)) begin errors++; $display("FAIL single_sob[%0d]: got %b expected %b", k, sob_q[k], k == 0); end
            end
        end
        checks++; if (bus.odv !== 1'b0) begin errors++; $display("FAIL single_odv_after: got %b expected 0", bus.odv); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] g;
        int e;
        clear_log();
        for (int i = 0; i < 64; i++) step(1'b1, i, 1'b1);
        for (int i = 0; i < 64; i++) step(1'b1, 100 + i, 1'b1);
        for (int j = 0; j < 150; j++) step(1'b0, 0, 1'b1);
        checks++; if (odv_cycles != 128) begin errors++; $display("FAIL b2b_odv_cycles: got %0d expected 128", odv_cycles); end
        checks++; if (last_odv - first_odv + 1 != 128) begin errors++; $display("FAIL b2b_contiguous: span %0d expected 128", last_odv - first_odv + 1); end
        checks++; if (got_q.size() != 128) begin errors++; $display("FAIL b2b_count: got %0d expected 128", got_q.size()); end
        for (int k = 0; k < 128; k++) begin
            e = (k < 64) ? exp_addr(k) : 100 + exp_addr(k - 64);
            g = (k < got_q.size()) ? got_q[k] : 12'bx;
            checks++; if (g !== 12'(e)) begin errors++; $display("FAIL b2b_data[%0d]: got %0d expected %0d", k, g, e); end
            if (k < sob_q.size()) begin
                checks++; if (sob_q[k] !== (k == 0 || k == 64)) begin errors++; $display("FAIL b2b_sob[%0d]: got %b expected %b", k, sob_q[k], k == 0 || k == 64); end
            end
        end
    endtask

    task automatic test_stall();
        logic [0:3] pat;
        logic [11:0] p_zzo;
        logic p_odv, p_rdy;
        logic [11:0] g;
        int stalls;
        pat = 4'b1001;
        stalls = 0;
        clear_log();
        for (int n = 0; n < 264; n++) begin
            p_odv = bus.odv; p_zzo = bus.zzo; p_rdy = bus.ordy;
            step(n < 64, n, pat[n % 4]);
            if (p_odv && !p_rdy) begin
                stalls++;
                checks++;
                if (bus.odv !== 1'b1 || bus.zzo !== p_zzo) begin
                    errors++; $display("FAIL stall_hold: odv=%b zzo=%0d expected odv=1 zzo=%0d", bus.odv, bus.zzo, p_zzo);
                end
            end
        end
        checks++; if (stalls < 10) begin errors++; $display("FAIL stall_occurred: got %0d stalls expected at least 10", stalls); end
        checks++; if (got_q.size() != 64) begin errors++; $display("FAIL stall_count: got %0d outputs expected 64", got_q.size()); end
        for (int k = 0; k < 64; k++) begin
            g = (k < got_q.size()) ? got_q[k] : 12'bx;
            checks++; if (g !== 12'(exp_addr(k))) begin errors++; $display("FAIL stall_data[%0d]: got %0d expected %0d", k, g, exp_addr(k)); end
        end
        step(1'b0, 0, 1'b1);
    endtask

    task automatic test_overflow();
        logic [11:0] g;
        int e;
        clear_log();
        for (int i = 0; i < 64; i++) step(1'b1, i, 1'b0);
        for (int i = 0; i < 64; i++) step(1'b1, 100 + i, 1'b0);
        for (int i = 0; i < 64; i++) begin
            step(1'b1, 200 + i, 1'b0);
            if (i == 0) begin
                checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", bus.ovf); end
            end
            if (i == 1) begin
                checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.ovf); end
            end
        end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL ovf_no_transfer: got %0d outputs expected 0", got_q.size()); end
        for (int j = 0; j < 300; j++) step(1'b0, 0, 1'b1);
        checks++; if (got_q.size() != 128) begin errors++; $display("FAIL ovf_count: got %0d outputs expected 128", got_q.size()); end
        for (int k = 0; k < 128; k++) begin
            e = (k < 64) ? exp_addr(k) : 100 + exp_addr(k - 64);
            g = (k < got_q.size()) ? got_q[k] : 12'bx;
            checks++; if (g !== 12'(e)) begin errors++; $display("FAIL ovf_data[%0d]: got %0d expected %0d", k, g, e); end
        end
        checks++; if (bus.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bus.ovf); end
    endtask

    task automatic test_mid_reset();
        logic [11:0] g;
        clear_log();
        for (int i = 0; i < 64; i++) step(1'b1, 300 + i, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b1, 500 + i, 1'b0);
        step(1'b0, 0, 1'b0);
        checks++; if (bus.odv !== 1'b1) begin errors++; $display("FAIL mrst_pre_odv: got %b expected 1", bus.odv); end
        rst = 1'b0;
        #1;
        checks++; if (bus.odv !== 1'b0) begin errors++; $display("FAIL mrst_odv: got %b expected 0", bus.odv); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL mrst_ovf: got %b expected 0", bus.ovf); end
        checks++; if (bus.osob !== 1'b0) begin errors++; $display("FAIL mrst_osob: got %b expected 0", bus.osob); end
        @(negedge clk);
        rst = 1'b1;
        clear_log();
        for (int i = 0; i < 64; i++) step(1'b1, 700 + i, 1'b1);
        for (int j = 0; j < 120; j++) step(1'b0, 0, 1'b1);
        checks++; if (got_q.size() != 64) begin errors++; $display("FAIL mrst_count: got %0d outputs expected 64", got_q.size()); end
        for (int k = 0; k < 64; k++) begin
            g = (k < got_q.size()) ? got_q[k] : 12'bx;
            checks++; if (g !== 12'(700 + exp_addr(k))) begin errors++; $display("FAIL mrst_data[%0d]: got %0d expected %0d", k, g, 700 + exp_addr(k)); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/zigzag_buffer.md
Name: zigzag_buffer

Overview:
- Consumer of the MDCT coefficient stream: accepts 12-bit coefficients in raster order, one per idv strobe, 64 per 8x8 block.
- Ping-pong buffers each block in two 64-entry banks.
- Re-emits each block in JPEG zigzag order toward the quantizer/entropy coder, with a valid/ready handshake on the output side.
- The MDCT side has no backpressure; the block absorbs one full block of downstream stall and flags overflow beyond that.

Parameters:
- DW, 12, coefficient width in bits (input and output).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- dcti  in  DW  coefficient from MDCT dcto
- idv  in  1  dcti valid, one coefficient per cycle when high
- zzo  out  DW  coefficient in zigzag order
- odv  out  1  zzo valid
- ordy  in  1  downstream ready; transfer when odv and ordy both high
- osob  out  1  start of block, high with zigzag index 0 only
- ovf  out  1  sticky overflow flag

Behaviour:
- Reset (rst low, asynchronous):
  - zzo=0, odv=0, osob=0, ovf=0.
  - Write bank=0, write count=0, both bank-full flags clear, reader in IDLE, read count=0.
- Write side:
  - Each idv cycle stores dcti at address wcnt = row*8+col of the current write bank and increments wcnt.
  - On the 64th sample (wcnt=63): set full[wbank], toggle wbank, wcnt wraps to 0.
  - idv arriving while full[wbank] is set: sample dropped, wcnt unchanged, ovf set to 1 and held until reset.
- Read side FSM:
  - IDLE -> STREAM when full[rbank] is set.
  - STREAM: synchronous-read RAM at address ZZ[rcnt] (standard JPEG zigzag table, 0,1,8,16,9,2,3,10,17,24,...,62,63); output register feeds zzo/odv.
  - rcnt advances on fetch when the output register is empty or is being consumed (odv&&ordy). One-entry prefetch, so full throughput with ordy=1.
  - When ordy is low, zzo/odv hold stable.
  - On the handshake of the 64th output: clear full[rbank], toggle rbank. If full[new rbank] is set, continue streaming with no bubble; else go to IDLE and drop odv after the last handshake.
- Latency: the first odv of a block asserts on the second rising edge after the edge that captured its 64th sample, provided the reader was IDLE.
- osob is high exactly while odv is high for zigzag index 0.
- Simultaneous events:
  - Bank release and a write to that bank in the same cycle: the clear has priority and the write is accepted.
  - idv and an output handshake in the same cycle are independent.
- Reset mid-operation discards partial and buffered blocks; no output until 64 new samples are received.
- No arithmetic on data; values pass bit-exact.

Optional Feature:
- Macro ZZ_TRANSPOSE_EN.
- Defined: input is column-major, so the write address is col*8+row (wcnt[2:0]<<3 | wcnt[5:3]) and output order is the zigzag of the transposed block.
- Undefined: input is row-major as above.
- No port or timing change either way.

Test Plan:
- Single block, dcti=index 0..63, ordy=1:
  - zzo sequence is 0,1,8,16,9,2,3,10,...,55,62,63.
  - First odv on the 2nd edge after the last idv; osob with 0 only; odv low afterwards.
- Two back-to-back blocks (values 0..63 then 100..163), ordy=1 -> 128 contiguous odv cycles, osob at outputs 0 and 64, second block begins with 100,101,108.
- Single block with ordy toggling 1,0,0,1 repeating -> zzo/odv stable across stalls, same 64-value sequence, no loss or duplication.
- Three blocks streamed with ordy=0 -> blocks 1-2 buffered; block 3 dropped; ovf=1 from the first block-3 idv. Then ordy=1 -> exactly 128 outputs (blocks 1 and 2) and ovf stays 1.
- rst low for 1 cycle after 30 samples, then a full 64-sample block -> odv=0 immediately and ovf=0; only the new block is emitted.
- With ZZ_TRANSPOSE_EN defined, dcti=index -> zzo sequence 0,8,1,2,9,16,24,...
